// File: rtl/sdhci_dat_receiver.sv
// sdhci_dat_receiver: receives one SD data block on a 1- or 4-bit DAT bus and checks per-line CRC16 and end bits.
module sdhci_dat_receiver #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        sd_clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [11:0] block_len_i,
    input  logic        bus_4bit_i,
    input  logic [3:0]  sd_dat_i,
    output logic [7:0]  data_o,
    output logic        data_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [3:0]  crc_err_o,
    output logic        end_err_o,
    output logic        timeout_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END, DONE} state_t;
    state_t state, state_nx;
    logic [TW-1:0] tcnt;
    logic [11:0] len, byte_cnt;
    logic [2:0] bit_cnt;
    logic [3:0] ccnt, mask;
    logic [7:0] sh, byte_nx;
    logic mode, accept, start_bit, timed_out, bit_last, last_byte;
    logic [15:0] crc [4];
    logic [15:0] rx_crc [4];

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        mask      = mode ? 4'hF : 4'h1;
        accept    = state == IDLE && start_i && block_len_i != 12'd0;
        start_bit = (sd_dat_i & mask) == 4'h0;
        timed_out = tcnt == TW'(TIMEOUT_CYCLES - 1);
        bit_last  = mode ? bit_cnt[0] : bit_cnt == 3'd7;
        byte_nx   = mode ? {sh[3:0], sd_dat_i} : {sh[6:0], sd_dat_i[0]};
        last_byte = byte_cnt == len - 12'd1;
    end

    always_ff @(posedge sd_clk_i)
        if (rst_i) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       state_nx = accept ? WAIT_START : IDLE;
            WAIT_START: state_nx = start_bit ? DATA : timed_out ? DONE : WAIT_START;
            DATA:       state_nx = bit_last && last_byte ? CRC : DATA;
            CRC:        state_nx = ccnt == 4'd15 ? END : CRC;
            END:        state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_o = state == WAIT_START || state == DATA || state == CRC || state == END;
        done_o = state == DONE;
    end

    always_ff @(posedge sd_clk_i) begin
        if (rst_i) begin
            data_o       <= 8'h00;
            data_valid_o <= 1'b0;
            crc_err_o    <= 4'h0;
            end_err_o    <= 1'b0;
            timeout_o    <= 1'b0;
            tcnt         <= '0;
            len          <= 12'd0;
            byte_cnt     <= 12'd0;
            bit_cnt      <= 3'd0;
            ccnt         <= 4'd0;
            sh           <= 8'h00;
            mode         <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                crc[n]    <= 16'h0000;
                rx_crc[n] <= 16'h0000;
            end
        end else begin
            data_valid_o <= 1'b0;
            if (accept) begin
                crc_err_o <= 4'h0;
                end_err_o <= 1'b0;
                timeout_o <= 1'b0;
                tcnt      <= '0;
                len       <= block_len_i;
                mode      <= bus_4bit_i;
                byte_cnt  <= 12'd0;
                bit_cnt   <= 3'd0;
                ccnt      <= 4'd0;
                for (int n = 0; n < 4; n++) begin
                    crc[n]    <= 16'h0000;
                    rx_crc[n] <= 16'h0000;
                end
            end
            case (state)
                WAIT_START: begin
                    tcnt <= tcnt + 1'b1;
                    if (!start_bit && timed_out) timeout_o <= 1'b1;
                end
                DATA: begin
                    sh      <= byte_nx;
                    bit_cnt <= bit_last ? 3'd0 : bit_cnt + 3'd1;
                    // Idle lines also run through a CRC; END masks them out.
                    for (int n = 0; n < 4; n++) crc[n] <= crc_step(crc[n], sd_dat_i[n]);
                    if (bit_last) begin
                        data_o       <= byte_nx;
                        data_valid_o <= 1'b1;
                        byte_cnt     <= byte_cnt + 12'd1;
                    end
                end
                CRC: begin
                    ccnt <= ccnt + 4'd1;
                    for (int n = 0; n < 4; n++) rx_crc[n] <= {rx_crc[n][14:0], sd_dat_i[n]};
                end
                END: begin
                    end_err_o <= |(~sd_dat_i & mask);
                    for (int n = 0; n < 4; n++) crc_err_o[n] <= mask[n] && crc[n] != rx_crc[n];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sdhci_dat_receiver.sv
// tb_sdhci_dat_receiver: table-driven and randomized checks of sdhci_dat_receiver against a polynomial-division model.
module tb_sdhci_dat_receiver;
    localparam int TO = 64;
    logic clk = 0, rst, start, mode;
    logic [11:0] blen;
    logic [3:0] dat;
    logic [7:0] data_o;
    logic data_valid_o, busy_o, done_o, end_err_o, timeout_o;
    logic [3:0] crc_err_o;

    sdhci_dat_receiver #(.TIMEOUT_CYCLES(TO)) dut (
        .sd_clk_i(clk), .rst_i(rst), .start_i(start), .block_len_i(blen),
        .bus_4bit_i(mode), .sd_dat_i(dat), .data_o(data_o), .data_valid_o(data_valid_o),
        .busy_o(busy_o), .done_o(done_o), .crc_err_o(crc_err_o), .end_err_o(end_err_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0, done_cnt = 0, gap_bad = 0, prev = -1;
    bit cur_mode;
    logic busy_at_done;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [15:0] tx_crc [4];

    typedef struct {
        bit m; int len; int kind; logic [3:0] corrupt; logic [3:0] endv; int pre;
        logic [3:0] ecrc; logic eend;
    } vec_t;
    vec_t tbl[12];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start && !busy_o && !rst) begin
            got_q.delete();
            prev = -1;
        end
        if (data_valid_o) begin
            got_q.push_back(data_o);
            if (prev >= 0 && cyc - prev != (cur_mode ? 2 : 8)) gap_bad++;
            prev = cyc;
        end
        if (done_o) begin
            done_cnt++;
            busy_at_done = busy_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] crc_div(input bit q[$]);
        logic [16:0] r = 17'h0;
        for (int i = 0; i < q.size() + 16; i++) begin
            r = {r[15:0], (i < q.size()) ? q[i] : 1'b0};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    function automatic logic [15:0] model_crc(input bit m, input int n);
        bit q[$];
        foreach (exp_q[i])
            if (m) begin
                q.push_back(exp_q[i][4+n]);
                q.push_back(exp_q[i][n]);
            end else
                for (int b = 7; b >= 0; b--) q.push_back(exp_q[i][b]);
        return crc_div(q);
    endfunction

    task automatic fill(input int len, input int kind);
        exp_q.delete();
        for (int i = 0; i < len; i++)
            exp_q.push_back(kind == 0 ? 8'h00 : kind == 1 ? 8'(i) : 8'($urandom));
    endtask

    task automatic prepare(input bit m, input logic [3:0] corrupt);
        for (int n = 0; n < 4; n++)
            tx_crc[n] = model_crc(m, n) ^ (corrupt[n] ? 16'(1 << $urandom_range(15, 0)) : 16'h0);
    endtask

    task automatic send_block(input bit m, input int pre, input logic [3:0] endv, input bit glitch);
        cur_mode = m;
        tick();
        start = 1; blen = 12'(exp_q.size()); mode = m; dat = 4'hF;
        tick();
        start = 0; blen = 12'($urandom); mode = 1'($urandom);
        repeat (pre) begin
            dat = m ? 4'hF : {3'($urandom), 1'b1};
            tick();
        end
        dat = m ? 4'h0 : {3'($urandom), 1'b0};
        tick();
        foreach (exp_q[i]) begin
            if (m) begin
                dat = exp_q[i][7:4];
                start = glitch && i == 0;
                tick();
                start = 0;
                dat = exp_q[i][3:0];
                tick();
            end else
                for (int b = 7; b >= 0; b--) begin
                    dat = {3'($urandom), exp_q[i][b]};
                    tick();
                end
        end
        for (int i = 15; i >= 0; i--) begin
            for (int n = 0; n < 4; n++) dat[n] = tx_crc[n][i];
            if (!m) dat[3:1] = 3'($urandom);
            tick();
        end
        dat = endv;
        tick();
        dat = 4'hF;
    endtask

    task automatic finish_block(input string tag, input int d0, input logic [3:0] ecrc, input logic eend);
        int t = 0, bad = 0;
        while (done_cnt == d0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk({tag, " done_count"}, done_cnt - d0, 1);
        chk({tag, " busy_at_done"}, busy_at_done, 0);
        chk({tag, " crc_err"}, crc_err_o, ecrc);
        chk({tag, " end_err"}, end_err_o, eend);
        chk({tag, " timeout"}, timeout_o, 0);
        if (got_q.size() != exp_q.size()) bad = 1;
        else foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
        chk({tag, " byte_errors"}, bad, 0);
        chk({tag, " strobe_gap"}, gap_bad, 0);
    endtask

    initial begin
        int d0;
        tbl[0]  = '{0, 2,    1, 4'h0, 4'hF, 0,  4'h0, 0};
        tbl[1]  = '{0, 1,    2, 4'h1, 4'hF, 3,  4'h1, 0};
        tbl[2]  = '{0, 3,    2, 4'hE, 4'hF, 5,  4'h0, 0};
        tbl[3]  = '{0, 2,    2, 4'h0, 4'hE, 0,  4'h0, 1};
        tbl[4]  = '{0, 2,    2, 4'h0, 4'h1, 63, 4'h0, 0};
        tbl[5]  = '{1, 4,    1, 4'h0, 4'hF, 0,  4'h0, 0};
        tbl[6]  = '{1, 8,    2, 4'h4, 4'hF, 2,  4'h4, 0};
        tbl[7]  = '{1, 2,    2, 4'h9, 4'hF, 63, 4'h9, 0};
        tbl[8]  = '{1, 1,    2, 4'h0, 4'h7, 1,  4'h0, 1};
        tbl[9]  = '{1, 512,  0, 4'h0, 4'hF, 0,  4'h0, 0};
        tbl[10] = '{1, 512,  0, 4'h4, 4'hF, 0,  4'h4, 0};
        tbl[11] = '{1, 2048, 2, 4'h0, 4'hF, 0,  4'h0, 0};
        rst = 1; start = 0; blen = 0; mode = 0; dat = 4'hF;
        repeat (2) tick();
        @(negedge clk);
        chk("reset_outputs", {data_o, data_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o}, 0);
        rst = 0;

        d0 = done_cnt;
        tick();
        start = 1; blen = 0; mode = 1; dat = 4'h0;
        tick();
        start = 0;
        repeat (80) tick();
        @(negedge clk);
        chk("len0_busy", busy_o, 0);
        chk("len0_done", done_cnt - d0, 0);
        dat = 4'hF;

        exp_q = '{8'h00, 8'h01};
        tx_crc[0] = 16'h1021; tx_crc[1] = 16'hFFFF; tx_crc[2] = 16'h0; tx_crc[3] = 16'h1234;
        d0 = done_cnt;
        send_block(0, 0, 4'hF, 0);
        finish_block("lit_crc_ok", d0, 4'h0, 0);
        tx_crc[0] = 16'h1020;
        d0 = done_cnt;
        send_block(0, 2, 4'hF, 0);
        finish_block("lit_crc_bad", d0, 4'h1, 0);

        d0 = done_cnt;
        tick();
        start = 1; blen = 5; mode = 1; dat = 4'hF;
        tick();
        start = 0;
        repeat (10) tick();
        @(negedge clk);
        chk("timeout_busy", busy_o, 1);
        for (int t = 0; t < 200 && done_cnt == d0; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("timeout_flag", timeout_o, 1);
        chk("timeout_done", done_cnt - d0, 1);
        chk("timeout_bytes", got_q.size(), 0);
        chk("timeout_crc_err", crc_err_o, 0);

        for (int i = 0; i < 12; i++) begin
            fill(tbl[i].len, tbl[i].kind);
            prepare(tbl[i].m, tbl[i].corrupt);
            d0 = done_cnt;
            send_block(tbl[i].m, tbl[i].pre, tbl[i].endv, i == 6);
            finish_block($sformatf("vec%0d", i), d0, tbl[i].ecrc, tbl[i].eend);
        end

        for (int i = 0; i < 15; i++) begin
            bit m;
            logic [3:0] corrupt, endv, msk;
            m = 1'($urandom);
            msk = m ? 4'hF : 4'h1;
            corrupt = 4'($urandom);
            endv = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'hF;
            fill($urandom_range(40, 1), 2);
            prepare(m, corrupt);
            d0 = done_cnt;
            send_block(m, $urandom_range(TO - 1, 0), endv, 1'($urandom));
            finish_block($sformatf("rnd%0d", i), d0, corrupt & msk, |(~endv & msk));
        end

        fill(512, 2);
        d0 = done_cnt;
        cur_mode = 1;
        tick();
        start = 1; blen = 512; mode = 1; dat = 4'hF;
        tick();
        start = 0; dat = 4'h0;
        tick();
        for (int i = 0; i < 5; i++) begin
            dat = exp_q[i][7:4]; tick();
            dat = exp_q[i][3:0]; tick();
        end
        dat = exp_q[5][7:4];
        tick();
        @(negedge clk);
        chk("abort_bytes_before", got_q.size(), 5);
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("abort_reset_outputs", {data_o, data_valid_o, busy_o, done_o, crc_err_o, end_err_o, timeout_o}, 0);
        repeat (30) begin
            dat = 4'($urandom);
            tick();
        end
        @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_no_more_bytes", got_q.size(), 5);
        dat = 4'hF;
        fill(6, 2);
        prepare(1, 4'h0);
        d0 = done_cnt;
        send_block(1, 1, 4'hF, 0);
        finish_block("after_abort", d0, 4'h0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sdhci_dat_receiver.md
SDHCI_DAT_RECEIVER -- requirements
Module: sdhci_dat_receiver

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1024, max sd_clk_i cycles from arm to start bit.
REQ-002 sd_clk_i  in  1  SD card clock; all logic on rising edge.
REQ-003 rst_i  in  1  synchronous, active-high reset.
REQ-004 start_i  in  1  one-cycle pulse; arms reception of one block.
REQ-005 block_len_i  in  12  block length in bytes, legal 1..2048; sampled when start_i is accepted.
REQ-006 bus_4bit_i  in  1  1 = 4-bit bus (DAT3..0), 0 = 1-bit bus (DAT0 only); sampled when start_i is accepted.
REQ-007 sd_dat_i  in  4  SD data lines, sampled every rising edge.
REQ-008 data_o  out  8  received byte, valid while data_valid_o=1.
REQ-009 data_valid_o  out  1  one-cycle strobe per received byte.
REQ-010 busy_o  out  1  high from accepted start_i until done_o.
REQ-011 done_o  out  1  one-cycle pulse at end of block, including errors and timeout.
REQ-012 crc_err_o  out  4  per-line CRC mismatch flag, held until next accepted start_i.
REQ-013 end_err_o  out  1  end bit sampled as 0 on any active line, held until next accepted start_i.
REQ-014 timeout_o  out  1  no start bit within TIMEOUT_CYCLES, held until next accepted start_i.

Function
REQ-015 States: IDLE, WAIT_START, DATA, CRC, END, DONE.
REQ-016 IDLE: start_i=1 with block_len_i!=0 -> WAIT_START, clear status flags, zero all four CRC registers; start_i with block_len_i=0 is ignored; start_i while busy_o=1 is ignored.
REQ-017 WAIT_START: all active lines =0 in the same cycle -> DATA (the start bit is not fed to the CRC); timeout counter reaching TIMEOUT_CYCLES first -> DONE with timeout_o=1.
REQ-018 DATA: each cycle, shift one bit per active line MSB-first; 1-bit mode takes 8 cycles per byte; 4-bit mode takes 2 cycles per byte, high nibble first, with DAT3 carrying bit 7/3 and DAT0 carrying bit 4/0.
REQ-019 data_valid_o is asserted with data_o in the cycle after the last bit of a byte is sampled; the byte counter wraps into CRC after block_len_i bytes.
REQ-020 Per-line CRC16: polynomial 0x1021 (x^16+x^12+x^5+1), init 0x0000, no final XOR, non-augmented serial form; fb=crc[15]^bit; crc={crc[14:0],0} ^ (fb ? 0x1021 : 0).
REQ-021 CRC check values: 16 zero bits give 0x0000; 15 zero bits followed by a single 1 give 0x1021; the 17-bit stream 0x11021 gives 0x0000.
REQ-022 CRC: for 16 cycles, shift received bits per active line into a separate rx_crc register, MSB first; the computed CRC is frozen during this phase.
REQ-023 END: sample one bit per active line; any 0 sets end_err_o; set crc_err_o[n] where computed!=received for each active line n; inactive lines report 0.
REQ-024 DONE: done_o=1 for exactly one cycle, busy_o falls in the same cycle, then -> IDLE.
REQ-025 In 1-bit mode DAT3..1 are ignored in every state.
REQ-026 Data bytes are still delivered when a CRC error occurs; the consumer discards the block on error.

Reset
REQ-027 While rst_i=1 at a rising edge: state=IDLE, data_o=0x00, data_valid_o=0, busy_o=0, done_o=0, crc_err_o=0x0, end_err_o=0, timeout_o=0, all counters and CRC registers zero.
REQ-028 Reset mid-block aborts immediately: no done_o pulse and no further data_valid_o; the next start_i after reset is accepted normally.

Verification
REQ-029 1-bit, len=2, DAT0 stream 0 | 0x00 0x01 | 0x1021 | 1 -> data_valid_o strobes with 0x00 then 0x01, done_o pulse, crc_err_o=0, end_err_o=0.
REQ-030 Same stream with CRC sent as 0x1020 -> crc_err_o=0x1, both bytes still delivered, done_o pulse.
REQ-031 4-bit, len=512, all data zero, each line CRC 0x0000, end bits 1 -> 512 strobes of 0x00 spaced 2 cycles apart, crc_err_o=0x0; with a corrupt CRC on DAT2 only -> crc_err_o=0x4.
REQ-032 Arm with all lines held 1 for TIMEOUT_CYCLES -> timeout_o=1, done_o pulse, no data_valid_o.
REQ-033 1-bit block with end bit 0 -> end_err_o=1, crc_err_o=0.
REQ-034 rst_i asserted after 5 bytes of a 512-byte block -> all outputs at reset values, no done_o; a following valid block completes cleanly.
